alu_input_sequencer: RTL and testbench
======================================

Name: alu_input_sequencer

Overview:
- Board-level front end for the ALU FPGA demo, directly upstream of the ALU.
- Replaces direct switch/key wiring with synchronised, debounced pushbutton control.
- An FSM walks through loading operand A, operand B and the opcode from SW[16:0], then holds all three stable with a valid flag for the ALU and hex display stage.
- Outputs are registered and glitch-free while switches move.

Parameters:
DEB_CYCLES, 500000, consecutive cycles a synchronised key level must differ from its debounced level before the debounced level flips (10 ms at 50 MHz); must be >= 2.

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous active-high reset
SW  input  18  raw board switches; SW[16] is the operand sign bit, SW[15:0] the operand magnitude field, SW[3:0] the opcode field, SW[17] ignored
KEY  input  4  raw pushbuttons, active-low; KEY[0]=enter, KEY[1]=back, KEY[3]=clear, KEY[2] ignored
portA  output  32  operand A, {16{SW[16]}} concatenated with SW[15:0] at capture
portB  output  32  operand B, same format
opcode  output  4  ALU opcode
op_valid  output  1  high while in RUN state
led_state  output  4  one-hot current state: bit0 LOAD_A, bit1 LOAD_B, bit2 LOAD_OP, bit3 RUN

Behaviour:
- Reset (RST high at an edge):
  - portA=0, portB=0, opcode=0, op_valid=0, state=LOAD_A, led_state=4'b0001.
  - SW and KEY synchroniser flops cleared to their released values (SW=0, KEY=1).
  - Debounced key levels=1, debounce counters=0, press pulses=0.
  - Reset asserted in the middle of a debounce or a load discards all in-flight activity.
- Synchronisation:
  - SW and KEY each pass through 2 flops (s1, s2).
  - All captures use the s2 value as it stands at the capturing edge.
- Debounce, one counter per used key:
  - If s2 equals the debounced level, the counter clears to 0.
  - Otherwise the counter increments. At an edge where the counter equals DEB_CYCLES-1 and s2 still differs, the debounced level flips and the counter clears.
  - A press pulse register is set for exactly one cycle at the edge where the debounced level goes 1->0. Release (0->1) produces no pulse.
  - A low glitch shorter than DEB_CYCLES cycles produces no pulse.
  - A held key produces exactly one pulse.
- Latency: let t0 be the edge at which s1 first samples KEY low and KEY stays low.
  - The pulse is high after edge t0+DEB_CYCLES+1.
  - The FSM and outputs update at edge t0+DEB_CYCLES+2.
- Pulse priority when pulses occur in the same cycle: clear > enter > back. Lower-priority pulses in that cycle are dropped.
- FSM transitions on enter:
  - LOAD_A: portA <= sext(SW_s2[16:0]); go to LOAD_B.
  - LOAD_B: portB <= sext(SW_s2[16:0]); go to LOAD_OP.
  - LOAD_OP: opcode <= SW_s2[3:0]; go to RUN; op_valid <= 1.
  - RUN: go to LOAD_A; op_valid <= 0; portA, portB and opcode keep their values.
- FSM transitions on back:
  - LOAD_B -> LOAD_A.
  - LOAD_OP -> LOAD_B.
  - RUN -> LOAD_OP, with op_valid <= 0.
  - LOAD_A: no effect.
  - Back never modifies data registers.
- Clear, in any state: portA, portB and opcode <= 0; op_valid <= 0; state <= LOAD_A. Debounce state is unaffected.
- Stability:
  - Data outputs change only at capture edges, clear, or reset.
  - Switch movement alone never changes any output.
- op_valid equals (state==RUN) registered. led_state always reflects the current state.

Test Plan:
1. Run with DEB_CYCLES=4. Assert RST for 2 cycles -> all outputs 0, led_state=0001. Hold KEY=4'hF for 20 cycles -> no change.
2. Full load:
   - SW=0x00005 then press KEY[0] 10 cycles -> portA=0x00000005, exactly at edge t0+6.
   - SW=0x1FFFD then press -> portB=0xFFFFFFFD.
   - SW=0x00002 then press -> opcode=4'h2, op_valid=1, led_state=1000.
3. Glitch and hold:
   - KEY[0] low for 3 cycles -> no state change.
   - KEY[0] held low for 200 cycles from LOAD_A -> advances only to LOAD_B.
   - Toggling SW meanwhile -> portA unchanged.
4. Back from RUN: press KEY[1] -> LOAD_OP, op_valid=0, opcode unchanged. Press KEY[1] twice more -> LOAD_A, then a further press -> stays LOAD_A.
5. Simultaneous:
   - Press KEY[0] and KEY[3] in the same cycle while in LOAD_OP with portA=5 -> all data 0, state LOAD_A, op_valid=0.
   - Press KEY[0] and KEY[1] together in LOAD_B -> enter wins, giving LOAD_OP.
6. Reset mid-debounce: KEY[0] low for 3 cycles, RST for 1 cycle, keep KEY[0] low -> pulse occurs only DEB_CYCLES+2 edges after post-reset s1 sampling, with one advance.

Source files
------------

// File: rtl/alu_input_sequencer.sv
// ALU demo front end: synchronised, debounced key FSM that loads
// operand A, operand B and opcode from switches and holds them for the ALU.
module alu_input_sequencer #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [17:0] SW,
  input  logic [3:0]  KEY,
  output logic [31:0] portA,
  output logic [31:0] portB,
  output logic [3:0]  opcode,
  output logic        op_valid,
  output logic [3:0]  led_state
);

  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

  typedef enum logic [3:0] {
    LOAD_A  = 4'b0001,
    LOAD_B  = 4'b0010,
    LOAD_OP = 4'b0100,
    RUN     = 4'b1000
  } state_t;

  state_t state, state_nx;

  logic [16:0]   sw_s1, sw_s2;
  logic [2:0]    key_s1, key_s2;
  logic [2:0]    deb, press;
  logic [CW-1:0] cnt [3];

  logic [31:0] a_nx, b_nx;
  logic [3:0]  op_nx;
  logic        v_nx;
  logic        do_clr, do_ent, do_back;
  logic [31:0] sw_sext;
  logic        unused_bits;

  assign unused_bits = ^{SW[17], KEY[2]};

  // key index 0=enter, 1=back, 2=clear
  always_ff @(posedge CLK) begin
    if (RST) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      key_s1 <= '1;
      key_s2 <= '1;
    end else begin
      sw_s1  <= SW[16:0];
      sw_s2  <= sw_s1;
      key_s1 <= {KEY[3], KEY[1:0]};
      key_s2 <= key_s1;
    end
  end

  // press fires only on a 1->0 flip of the debounced level
  always_ff @(posedge CLK) begin
    if (RST) begin
      deb   <= '1;
      press <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if (key_s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CMAX) begin
          deb[i]   <= key_s2[i];
          cnt[i]   <= '0;
          press[i] <= deb[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign do_clr  = press[2];
  assign do_ent  = press[0] & ~press[2];
  assign do_back = press[1] & ~press[0] & ~press[2];
  assign sw_sext = {{16{sw_s2[16]}}, sw_s2[15:0]};

  always_comb begin
    state_nx = state;
    a_nx     = portA;
    b_nx     = portB;
    op_nx    = opcode;
    v_nx     = op_valid;
    unique case (1'b1)
      do_clr: begin
        state_nx = LOAD_A;
        a_nx     = '0;
        b_nx     = '0;
        op_nx    = '0;
        v_nx     = 1'b0;
      end
      do_ent: begin
        unique case (state)
          LOAD_A: begin
            a_nx     = sw_sext;
            state_nx = LOAD_B;
          end
          LOAD_B: begin
            b_nx     = sw_sext;
            state_nx = LOAD_OP;
          end
          LOAD_OP: begin
            op_nx    = sw_s2[3:0];
            state_nx = RUN;
            v_nx     = 1'b1;
          end
          RUN: begin
            state_nx = LOAD_A;
            v_nx     = 1'b0;
          end
          default: state_nx = LOAD_A;
        endcase
      end
      do_back: begin
        unique case (state)
          LOAD_A:  state_nx = LOAD_A;
          LOAD_B:  state_nx = LOAD_A;
          LOAD_OP: state_nx = LOAD_B;
          RUN: begin
            state_nx = LOAD_OP;
            v_nx     = 1'b0;
          end
          default: state_nx = LOAD_A;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= LOAD_A;
      portA    <= '0;
      portB    <= '0;
      opcode   <= '0;
      op_valid <= 1'b0;
    end else begin
      state    <= state_nx;
      portA    <= a_nx;
      portB    <= b_nx;
      opcode   <= op_nx;
      op_valid <= v_nx;
    end
  end

  assign led_state = state;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Directed bench for alu_input_sequencer with DEB_CYCLES=4:
// vector table of key presses plus hand sequences for timing corners.
module tb_alu_input_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [17:0] SW;
  logic [3:0]  KEY;
  logic [31:0] portA, portB;
  logic [3:0]  opcode;
  logic        op_valid;
  logic [3:0]  led_state;

  int n_run  = 0;
  int n_fail = 0;

  alu_input_sequencer #(.DEB_CYCLES(4)) dut (
    .CLK(CLK),
    .RST(RST),
    .SW(SW),
    .KEY(KEY),
    .portA(portA),
    .portB(portB),
    .opcode(opcode),
    .op_valid(op_valid),
    .led_state(led_state)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [17:0] sw;
    logic [3:0]  mask;
    logic [7:0]  hold;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        v;
    logic [3:0]  led;
  } vec_t;

  vec_t tv [11];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] op,
                         input logic v, input logic [3:0] led);
    chk({tag, ".portA"}, portA, a);
    chk({tag, ".portB"}, portB, b);
    chk({tag, ".opcode"}, {28'd0, opcode}, {28'd0, op});
    chk({tag, ".op_valid"}, {31'd0, op_valid}, {31'd0, v});
    chk({tag, ".led"}, {28'd0, led_state}, {28'd0, led});
  endtask

  task automatic run_vec(input int i);
    SW = tv[i].sw;
    repeat (3) tick();
    KEY = ~tv[i].mask;
    repeat (int'(tv[i].hold)) tick();
    KEY = 4'hF;
    repeat (12) tick();
    chk_all($sformatf("vec%0d", i), tv[i].a, tv[i].b,
            tv[i].op, tv[i].v, tv[i].led);
  endtask

  initial begin
    tv[0]  = '{18'h1FFFD, 4'b0001, 8'd10, 32'h5, 32'hFFFFFFFD, 4'h0, 1'b0, 4'b0100};
    tv[1]  = '{18'h00002, 4'b0001, 8'd10, 32'h5, 32'hFFFFFFFD, 4'h2, 1'b1, 4'b1000};
    tv[2]  = '{18'h00009, 4'b0001, 8'd3,  32'h5, 32'hFFFFFFFD, 4'h2, 1'b1, 4'b1000};
    tv[3]  = '{18'h00009, 4'b0010, 8'd10, 32'h5, 32'hFFFFFFFD, 4'h2, 1'b0, 4'b0100};
    tv[4]  = '{18'h00009, 4'b0010, 8'd10, 32'h5, 32'hFFFFFFFD, 4'h2, 1'b0, 4'b0010};
    tv[5]  = '{18'h00009, 4'b0010, 8'd10, 32'h5, 32'hFFFFFFFD, 4'h2, 1'b0, 4'b0001};
    tv[6]  = '{18'h00009, 4'b0010, 8'd10, 32'h5, 32'hFFFFFFFD, 4'h2, 1'b0, 4'b0001};
    tv[7]  = '{18'h00005, 4'b0001, 8'd10, 32'h5, 32'hFFFFFFFD, 4'h2, 1'b0, 4'b0010};
    tv[8]  = '{18'h12345, 4'b0001, 8'd10, 32'h5, 32'hFFFF2345, 4'h2, 1'b0, 4'b0100};
    tv[9]  = '{18'h00006, 4'b1001, 8'd10, 32'h0, 32'h0,        4'h0, 1'b0, 4'b0001};
    tv[10] = '{18'h00003, 4'b0011, 8'd10, 32'h7, 32'h3,        4'h0, 1'b0, 4'b0100};

    RST = 1'b1;
    SW  = 18'h00005;
    KEY = 4'hF;
    repeat (2) tick();
    RST = 1'b0;
    chk_all("reset", 32'h0, 32'h0, 4'h0, 1'b0, 4'b0001);
    repeat (20) tick();
    chk_all("idle", 32'h0, 32'h0, 4'h0, 1'b0, 4'b0001);

    // enter pressed: update must land exactly 7 edges after drive
    KEY = 4'hE;
    repeat (6) tick();
    chk("lat.before", portA, 32'h0);
    tick();
    chk("lat.at", portA, 32'h5);
    chk("lat.led", {28'd0, led_state}, 32'h2);
    repeat (3) tick();
    KEY = 4'hF;
    repeat (12) tick();

    for (int i = 0; i < 10; i++) run_vec(i);

    // long hold from LOAD_A with switches moving after capture
    SW = 18'h00007;
    repeat (3) tick();
    KEY = 4'hE;
    repeat (20) tick();
    for (int i = 0; i < 180; i++) begin
      SW = 18'($urandom);
      tick();
    end
    chk("hold.portA", portA, 32'h7);
    KEY = 4'hF;
    repeat (12) tick();
    chk_all("hold", 32'h7, 32'h0, 4'h0, 1'b0, 4'b0010);

    run_vec(10);

    // reset lands mid-debounce; key kept low through it
    KEY = 4'hE;
    repeat (3) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk_all("rstmid", 32'h0, 32'h0, 4'h0, 1'b0, 4'b0001);
    repeat (6) tick();
    chk("rstmid.before", {28'd0, led_state}, 32'h1);
    tick();
    chk("rstmid.at", {28'd0, led_state}, 32'h2);
    repeat (30) tick();
    KEY = 4'hF;
    repeat (12) tick();
    chk_all("rstmid.end", 32'h3, 32'h0, 4'h0, 1'b0, 4'b0010);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
